car_power_ctrl: RTL and testbench

Top-level power sequencer for the car.
- Power-on by long press of the power button; power-off by long press, by an idle timeout with no drive command, or by the no-barrier detector's power_off request.
- Gates the detector through detect_start after an arming delay.
- Reports why the last shutdown happened.
- Sits between the debounced button/drive-command logic and the detector and motor enables.

---
 rtl/car_power_ctrl.sv | 170 +++++++++++++++++
 tb/tb_car_power_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_power_ctrl.sv
// Car power sequencer: long-press on/off, idle and detector shutdown,
// armed detector enable and last-shutdown cause, all outputs registered.
module car_power_ctrl #(
  parameter int ON_HOLD_CYC  = 50,
  parameter int OFF_HOLD_CYC = 50,
  parameter int IDLE_CYC     = 500,
  parameter int ARM_DELAY    = 10,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       drive_cmd,
  input  logic       detect_off,
  output logic       power_on,
  output logic       detect_start,
  output logic [1:0] shutdown_cause,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_OFF          = 3'b000,
    S_PRESS_ON     = 3'b001,
    S_WAIT_REL_ON  = 3'b010,
    S_ARMING       = 3'b011,
    S_RUN          = 3'b100,
    S_PRESS_OFF    = 3'b101,
    S_WAIT_REL_OFF = 3'b110
  } state_t;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_BTN  = 2'b01;
  localparam logic [1:0] C_DET  = 2'b10;
  localparam logic [1:0] C_IDLE = 2'b11;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_HOLD_CYC);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_HOLD_CYC);
  localparam logic [CNT_W-1:0] IDL_LIM = CNT_W'(IDLE_CYC);
  localparam logic [CNT_W-1:0] ARM_LIM = CNT_W'(ARM_DELAY);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_n;
  logic [1:0]       cause;
  logic [1:0]       cause_n;
  logic             on_n;
  logic             det_n;

  // Limits are checked on cnt+1 before any increment, so no wrap.
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] idle_inc;
  assign cnt_inc  = cnt + ONE;
  assign idle_inc = idle_cnt + ONE;

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    idle_n  = '0;
    cause_n = cause;
    unique case (state)
      S_OFF: begin
        if (power_btn) begin
          if (ON_LIM == ONE) begin
            state_n = S_WAIT_REL_ON;
            cause_n = C_NONE;
          end else begin
            state_n = S_PRESS_ON;
            cnt_n   = ONE;
          end
        end
      end
      S_PRESS_ON: begin
        if (!power_btn) begin
          state_n = S_OFF;
        end else if (cnt_inc == ON_LIM) begin
          state_n = S_WAIT_REL_ON;
          cause_n = C_NONE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT_REL_ON: begin
        if (!power_btn) state_n = S_ARMING;
      end
      S_ARMING: begin
        if (cnt_inc == ARM_LIM) state_n = S_RUN;
        else cnt_n = cnt_inc;
      end
      S_RUN: begin
        if (detect_off) begin
          state_n = S_OFF;
          cause_n = C_DET;
        end else if (!drive_cmd && idle_inc == IDL_LIM) begin
          state_n = S_OFF;
          cause_n = C_IDLE;
        end else if (power_btn) begin
          if (OFF_LIM == ONE) begin
            state_n = S_WAIT_REL_OFF;
            cause_n = C_BTN;
          end else begin
            state_n = S_PRESS_OFF;
            cnt_n   = ONE;
          end
        end else begin
          idle_n = drive_cmd ? '0 : idle_inc;
        end
      end
      S_PRESS_OFF: begin
        if (detect_off) begin
          state_n = S_OFF;
          cause_n = C_DET;
        end else if (!power_btn) begin
          state_n = S_RUN;
        end else if (cnt_inc == OFF_LIM) begin
          state_n = S_WAIT_REL_OFF;
          cause_n = C_BTN;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT_REL_OFF: begin
        if (!power_btn) state_n = S_OFF;
      end
      default: begin
        state_n = S_OFF;
      end
    endcase
  end

  always_comb begin
    on_n  = 1'b0;
    det_n = 1'b0;
    unique case (state_n)
      S_WAIT_REL_ON,
      S_ARMING:    on_n = 1'b1;
      S_RUN,
      S_PRESS_OFF: begin
        on_n  = 1'b1;
        det_n = 1'b1;
      end
      default:     on_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_OFF;
      cnt          <= '0;
      idle_cnt     <= '0;
      cause        <= C_NONE;
      power_on     <= 1'b0;
      detect_start <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idle_cnt     <= idle_n;
      cause        <= cause_n;
      power_on     <= on_n;
      detect_start <= det_n;
    end
  end

  assign shutdown_cause = cause;
  assign state_dbg      = state;

endmodule

// File: tb/tb_car_power_ctrl.sv
// Bench for car_power_ctrl: mode-level model compared every cycle,
// plus literal expectations on directed scenarios.
module tb_car_power_ctrl;

  localparam int ON   = 4;
  localparam int OFF  = 4;
  localparam int IDLE = 8;
  localparam int ARM  = 3;

  localparam int M_OFF      = 0;
  localparam int M_HELD_ON  = 1;
  localparam int M_ARM      = 2;
  localparam int M_RUN      = 3;
  localparam int M_HELD_OFF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_btn = 1'b0;
  logic       drive_cmd = 1'b0;
  logic       detect_off = 1'b0;
  logic       power_on;
  logic       detect_start;
  logic [1:0] shutdown_cause;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  car_power_ctrl #(
    .ON_HOLD_CYC (ON),
    .OFF_HOLD_CYC(OFF),
    .IDLE_CYC    (IDLE),
    .ARM_DELAY   (ARM),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .power_btn     (power_btn),
    .drive_cmd     (drive_cmd),
    .detect_off    (detect_off),
    .power_on      (power_on),
    .detect_start  (detect_start),
    .shutdown_cause(shutdown_cause),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Model: coarse modes; "streak" = consecutive high samples in a mode.
  typedef struct {
    int mode;
    int streak;
    int arm;
    int idle;
    int cause;
  } model_t;

  model_t m;

  function automatic model_t model_rst();
    model_t r;
    r.mode = M_OFF;
    r.streak = 0;
    r.arm = 0;
    r.idle = 0;
    r.cause = 0;
    return r;
  endfunction

  function automatic model_t go_off(model_t c, int why);
    model_t n = c;
    n.mode = M_OFF;
    n.streak = 0;
    n.idle = 0;
    n.cause = why;
    return n;
  endfunction

  function automatic model_t model_next(model_t c, logic b, logic d,
                                        logic o);
    model_t n = c;
    case (c.mode)
      M_OFF: begin
        if (b) begin
          n.streak = c.streak + 1;
          if (n.streak == ON) begin
            n.mode = M_HELD_ON;
            n.streak = 0;
            n.cause = 0;
          end
        end else begin
          n.streak = 0;
        end
      end
      M_HELD_ON: begin
        if (!b) begin
          n.mode = M_ARM;
          n.arm = 0;
        end
      end
      M_ARM: begin
        n.arm = c.arm + 1;
        if (n.arm == ARM) begin
          n.mode = M_RUN;
          n.arm = 0;
          n.idle = 0;
          n.streak = 0;
        end
      end
      M_RUN: begin
        if (o) begin
          n = go_off(c, 2);
        end else if (c.streak == 0) begin
          if (!d && c.idle + 1 == IDLE) begin
            n = go_off(c, 3);
          end else if (b) begin
            n.idle = 0;
            n.streak = 1;
            if (OFF == 1) begin
              n.mode = M_HELD_OFF;
              n.streak = 0;
              n.cause = 1;
            end
          end else begin
            n.idle = d ? 0 : c.idle + 1;
          end
        end else if (!b) begin
          n.streak = 0;
        end else begin
          n.streak = c.streak + 1;
          if (n.streak == OFF) begin
            n.mode = M_HELD_OFF;
            n.streak = 0;
            n.cause = 1;
          end
        end
      end
      M_HELD_OFF: begin
        if (!b) n.mode = M_OFF;
      end
      default: n = model_rst();
    endcase
    return n;
  endfunction

  function automatic int exp_dbg(model_t c);
    case (c.mode)
      M_OFF:      return (c.streak > 0) ? 1 : 0;
      M_HELD_ON:  return 2;
      M_ARM:      return 3;
      M_RUN:      return (c.streak > 0) ? 5 : 4;
      M_HELD_OFF: return 6;
      default:    return 7;
    endcase
  endfunction

  function automatic int exp_on(model_t c);
    return (c.mode == M_HELD_ON || c.mode == M_ARM || c.mode == M_RUN)
           ? 1 : 0;
  endfunction

  function automatic int exp_det(model_t c);
    return (c.mode == M_RUN) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_rst();
    else m <= model_next(m, power_btn, drive_cmd, detect_off);
  end

  always @(negedge clk) begin
    chk("cmp_power_on", int'(power_on), exp_on(m));
    chk("cmp_detect_start", int'(detect_start), exp_det(m));
    chk("cmp_cause", int'(shutdown_cause), m.cause);
    chk("cmp_state_dbg", int'(state_dbg), exp_dbg(m));
  end

  task automatic step(logic b, logic d, logic o);
    power_btn = b;
    drive_cmd = d;
    detect_off = o;
    @(posedge clk);
    #1;
  endtask

  task automatic power_up();
    repeat (ON) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (ARM) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_zero(string name);
    chk({name, "_pwr"}, int'(power_on), 0);
    chk({name, "_det"}, int'(detect_start), 0);
    chk({name, "_cause"}, int'(shutdown_cause), 0);
    chk({name, "_dbg"}, int'(state_dbg), 0);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // power-on, rise on 4th sample, detector 3 edges after release
    repeat (ON) step(1'b1, 1'b0, 1'b0);
    chk("on_pwr", int'(power_on), 1);
    chk("on_dbg", int'(state_dbg), 2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("arm_det_early", int'(detect_start), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("arm_det", int'(detect_start), 1);
    chk("arm_dbg", int'(state_dbg), 4);
    chk("arm_cause", int'(shutdown_cause), 0);

    // short press in RUN
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("short_run_dbg", int'(state_dbg), 5);
    step(1'b0, 1'b1, 1'b0);
    chk("short_run_back", int'(state_dbg), 4);
    chk("short_run_det", int'(detect_start), 1);

    // button off, held long, then release
    repeat (OFF) step(1'b1, 1'b1, 1'b0);
    chk("btnoff_pwr", int'(power_on), 0);
    chk("btnoff_cause", int'(shutdown_cause), 1);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("btnoff_hold_dbg", int'(state_dbg), 6);
    chk("btnoff_hold_pwr", int'(power_on), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("btnoff_rel_dbg", int'(state_dbg), 0);
    chk("btnoff_rel_cause", int'(shutdown_cause), 1);

    // short press in OFF
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("short_off_dbg", int'(state_dbg), 0);
    chk("short_off_pwr", int'(power_on), 0);

    // detector pulse in RUN
    power_up();
    chk("reon_cause", int'(shutdown_cause), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("detoff_pwr", int'(power_on), 0);
    chk("detoff_det", int'(detect_start), 0);
    chk("detoff_cause", int'(shutdown_cause), 2);

    // detector beats a completing off-press
    power_up();
    repeat (OFF - 1) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("detwin_cause", int'(shutdown_cause), 2);
    chk("detwin_dbg", int'(state_dbg), 0);
    step(1'b0, 1'b0, 1'b0);

    // idle timeout on the 8th edge
    power_up();
    repeat (IDLE - 1) step(1'b0, 1'b0, 1'b0);
    chk("idle_pre", int'(state_dbg), 4);
    step(1'b0, 1'b0, 1'b0);
    chk("idle_dbg", int'(state_dbg), 0);
    chk("idle_cause", int'(shutdown_cause), 3);

    // drive command at cycle 7 restarts the idle window
    power_up();
    repeat (6) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (IDLE - 1) step(1'b0, 1'b0, 1'b0);
    chk("idle2_pre", int'(power_on), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("idle2_cause", int'(shutdown_cause), 3);

    // async reset mid-ARMING
    repeat (ON) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_arm");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_short_pwr", int'(power_on), 0);
    chk("rst_short_dbg", int'(state_dbg), 0);

    // async reset mid-PRESS_OFF
    power_up();
    repeat (2) step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_dbg", int'(state_dbg), 5);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_poff");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
